// File: rtl/mm_pkg.sv
// Shared types for the matrix-multiply job scheduler: FSM encoding, status record, width helpers.
package mm_pkg;

  localparam int unsigned TagW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StReport,
    StDrain,
    StAbort
  } state_e;

  typedef struct packed {
    logic [TagW-1:0] tag;
    logic            error;
  } sts_t;

  function automatic int unsigned mem_addr_w(input int unsigned l_ram_size,
                                             input int unsigned bank_w);
    return bank_w + 2 * l_ram_size + 1;
  endfunction

  // Smallest width that still holds timeout-1.
  function automatic int unsigned wd_w(input int unsigned timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mm_cmd_fifo.sv
// First-word-fall-through command FIFO; Depth must be a power of two, at least 2.
module mm_cmd_fifo #(
  parameter int unsigned Width = 6,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_empty_nxt
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_count, w_count_d;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - 1'b1;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_count <= w_count_d;
      r_full  <= (w_count_d == CntW'(Depth));
      r_empty <= (w_count_d == '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_empty_nxt = (w_count_d == '0);

endmodule

// File: rtl/mm_scheduler.sv
// Queues {bank, tag} jobs, sequences the multiplier core through each one with a RUN watchdog,
// and steers the core's memory port onto the job's BRAM bank.
module mm_scheduler
  import mm_pkg::*;
#(
  parameter int unsigned L_RAM_SIZE     = 3,
  parameter int unsigned BITWIDTH       = 32,
  parameter int unsigned BANK_W         = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned AddrW         = mem_addr_w(L_RAM_SIZE, BANK_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BANK_W-1:0]     cmd_bank,
  input  logic [TagW-1:0]       cmd_tag,
  output logic                  sts_valid,
  input  logic                  sts_ready,
  output logic [TagW-1:0]       sts_tag,
  output logic                  sts_error,
  output logic                  core_start,
  output logic                  core_rst,
  input  logic                  core_done,
  input  logic [2*L_RAM_SIZE:0] core_addr,
  input  logic                  core_we,
  input  logic [BITWIDTH-1:0]   core_wrdata,
  output logic [BITWIDTH-1:0]   core_rddata,
  output logic [AddrW-1:0]      mem_addr,
  output logic                  mem_we,
  output logic [BITWIDTH-1:0]   mem_wrdata,
  input  logic [BITWIDTH-1:0]   mem_rddata,
  output logic                  busy
);

  localparam int unsigned WdW = wd_w(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES - 1);

  state_e                   r_state, w_state_d;
  logic [BANK_W-1:0]        r_bank;
  sts_t                     r_sts;
  logic                     w_err_d;
  logic [WdW-1:0]           r_wd, w_wd_d;
  logic                     r_abort_cnt, w_abort_cnt_d;
  logic                     r_core_start, r_core_rst, r_sts_valid, r_mem_en, r_busy;
  logic                     w_pop, w_fifo_full, w_fifo_empty, w_fifo_empty_nxt;
  logic [BANK_W+TagW-1:0]   w_fifo_head;

  mm_cmd_fifo #(
    .Width (BANK_W + TagW),
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (cmd_valid),
    .i_data      ({cmd_bank, cmd_tag}),
    .i_pop       (w_pop),
    .o_data      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_empty_nxt (w_fifo_empty_nxt)
  );

  // A new job never starts while the core still reports done from the previous one.
  assign w_pop = (r_state == StIdle) && !w_fifo_empty && !core_done;

  always_comb begin
    w_state_d     = r_state;
    w_wd_d        = r_wd;
    w_abort_cnt_d = r_abort_cnt;
    w_err_d       = r_sts.error;
    unique case (r_state)
      StIdle: if (w_pop) w_state_d = StStart;
      StStart: begin
        w_wd_d    = '0;
        w_state_d = StRun;
      end
      StRun: begin
        w_abort_cnt_d = 1'b0;
        if (r_wd != '1) w_wd_d = r_wd + 1'b1;
        if (core_done) begin
          w_state_d = StReport;
          w_err_d   = 1'b0;
        end else if (r_wd == WdLimit) begin
          w_state_d = StAbort;
          w_err_d   = 1'b1;
        end
      end
      StAbort: begin
        w_abort_cnt_d = 1'b1;
        if (r_abort_cnt) w_state_d = StReport;
      end
      StReport: if (sts_ready) w_state_d = StDrain;
      StDrain:  if (!core_done) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state so they are glitch-free and align with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_bank       <= '0;
      r_sts        <= '0;
      r_wd         <= '0;
      r_abort_cnt  <= 1'b0;
      r_core_start <= 1'b0;
      r_core_rst   <= 1'b1;
      r_sts_valid  <= 1'b0;
      r_mem_en     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wd        <= w_wd_d;
      r_abort_cnt <= w_abort_cnt_d;
      r_sts.error <= w_err_d;
      if (w_pop) begin
        r_bank    <= w_fifo_head[BANK_W+TagW-1:TagW];
        r_sts.tag <= w_fifo_head[TagW-1:0];
      end
      r_core_start <= (w_state_d == StStart);
      r_core_rst   <= (w_state_d == StAbort);
      r_sts_valid  <= (w_state_d == StReport);
      r_mem_en     <= (w_state_d == StStart) || (w_state_d == StRun);
      r_busy       <= (w_state_d != StIdle) || !w_fifo_empty_nxt;
    end
  end

  assign cmd_ready   = !w_fifo_full;
  assign sts_valid   = r_sts_valid;
  assign sts_tag     = r_sts.tag;
  assign sts_error   = r_sts.error;
  assign core_start  = r_core_start;
  assign core_rst    = r_core_rst;
  assign busy        = r_busy;
  assign core_rddata = mem_rddata;
  assign mem_addr    = r_mem_en ? {r_bank, core_addr} : '0;
  assign mem_we      = r_mem_en && core_we;
  assign mem_wrdata  = r_mem_en ? core_wrdata : '0;

endmodule
